i2s_frame_ctrl: RTL and testbench
=================================

I2S_FRAME_CTRL -- requirements
Module: i2s_frame_ctrl

Interface
REQ-001 The module SHALL have one parameter, DIVIDER, with default 4: ck cycles per sck half-period, legal range 2..255.
REQ-002 The module SHALL have these ports, one per line as name, direction, width, meaning; clock and reset first; one clock, reset asynchronous and active-low:
- ck  in  1  system clock; all logic on posedge ck
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request, level
- sck  out  1  I2S bit clock, registered
- ws  out  1  I2S word select, registered
- frame_posn  out  6  bit position in the 64-bit frame
- left_in  in  16  left sample from the receiver
- right_in  in  16  right sample from the receiver
- out_valid  out  1  sample pair available
- out_ready  in  1  consumer accepts the pair
- out_left  out  16  held left sample
- out_right  out  16  held right sample
- out_seq  out  8  frame sequence number of the held pair
- overrun  out  1  sticky: a pair was dropped
- clr_overrun  in  1  clears overrun
- running  out  1  high in RUN and STOPPING

Function
REQ-003 The controller SHALL be a state machine with three states: IDLE, RUN and STOPPING.
REQ-004 In IDLE: sck=0, prescaler=0, frame_posn=0; en=1 moves the state to RUN on the next ck.
REQ-005 In RUN and STOPPING, the prescaler SHALL count 0..DIVIDER-1; at the terminal count it wraps to 0 and sck toggles.
REQ-006 On each sck 1->0 toggle, frame_posn SHALL increment modulo 64; 63 wraps to 0.
REQ-007 The sck period SHALL equal 2*DIVIDER ck cycles, and the frame SHALL equal 128*DIVIDER ck cycles.
REQ-008 ws SHALL equal frame_posn[5], registered in the same cycle frame_posn updates: ws=0 for the left slot (0..31), ws=1 for the right slot (32..63).
REQ-009 At the frame_posn 50->51 increment (right word latched by the receiver at 49), the controller SHALL capture left_in and right_in into out_left and out_right.
REQ-010 The same capture event SHALL load out_seq with the internal frame counter and set out_valid.
REQ-011 The internal frame counter SHALL increment after each capture event and wrap at 255 to 0.
REQ-012 Handshake: a transfer occurs on a ck where out_valid=1 and out_ready=1; out_valid clears the next ck unless a capture occurs in that same cycle.
REQ-013 While out_valid=1, out_left, out_right and out_seq SHALL be held stable.
REQ-014 Capture with out_valid=1 and no transfer that cycle: the new pair SHALL be dropped, the held data kept, overrun set to 1, and the frame counter still incremented.
REQ-015 Capture and transfer in the same cycle: the new pair SHALL be loaded, out_valid stays 1, and overrun is not set.
REQ-016 clr_overrun=1 SHALL clear overrun the next ck; if a set event occurs in the same cycle, the set wins.
REQ-017 In RUN, en=0 SHALL move the state to STOPPING; the current frame completes.
REQ-018 In STOPPING, the state SHALL move to IDLE on the 63->0 wrap, with sck=0 and frame_posn=0.
REQ-019 In STOPPING, en=1 SHALL return the state to RUN with no frame discontinuity.
REQ-020 IDLE SHALL never emit a partial frame.
REQ-021 A capture event in STOPPING SHALL still be processed.
REQ-022 out_valid SHALL be unaffected by the IDLE state and persist until accepted.

Reset
REQ-023 rst_n=0 SHALL immediately force: state IDLE; sck, ws and frame_posn 0; prescaler and frame counter 0.
REQ-024 rst_n=0 SHALL also immediately force out_valid, out_left, out_right, out_seq, overrun and running to 0.
REQ-025 A reset mid-frame SHALL abandon the frame; the first frame after release starts at frame_posn=0.

Structure
REQ-026 A shared package SHALL hold: FRAME_LEN=64, WORD_LEN=32, EOW=17, CAPTURE_POSN=50, and the state encoding (IDLE=0, RUN=1, STOPPING=2).
REQ-027 The prescaler and sck toggle SHALL be one sub-module, i2s_sck_gen, outputting sck and a one-ck fall strobe.
REQ-028 The FSM, frame counter and output register SHALL stay in the top module.

Verification (DIVIDER=2)
REQ-029 The bench SHALL cover these directed scenarios:
- en=1 from reset -> sck period 4 ck; frame_posn 0..63 then 0; ws=1 exactly for posn 32..63; frame = 256 ck.
- left_in=0x1234, right_in=0xABCD, out_ready=1 -> one out_valid pulse per frame with those values; out_seq 0,1,2.
- out_ready=0 for 3 frames -> held pair is seq 0; overrun=1 after frame 2; after clr_overrun and accept, overrun=0 and the next pair has seq 3.
- en=0 at frame_posn 10 -> STOPPING, frame completes, IDLE at the wrap, sck=0; en=1 at posn 40 while STOPPING -> stays RUN with continuous posn.
- rst_n low at frame_posn 20 with out_valid=1 -> all outputs 0 asynchronously; restart at posn 0, seq 0.
- capture coincident with out_ready=1 -> out_valid stays high, new data loaded, overrun=0.

Source files
------------

// File: rtl/i2s_frame_ctrl_pkg.sv
// I2S frame controller shared definitions: frame geometry, capture point, FSM encoding.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package i2s_frame_ctrl_pkg;

  localparam int FRAME_LEN    = 64;  // bit slots per stereo frame
  localparam int WORD_LEN     = 32;  // bit slots per channel word
  localparam int EOW          = 17;  // first slot after a 16-bit sample (MSB delayed one slot)
  localparam int CAPTURE_POSN = 50;  // receiver has latched the right word by this slot

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  // Next bit position within the frame, wrapping 63 -> 0.
  function automatic logic [5:0] posn_inc(input logic [5:0] posn);
    return 6'((int'(posn) + 1) % FRAME_LEN);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock generator: prescaler counts 0..DIVIDER-1 and toggles sck at terminal count.
// Latency: sck registered; fall strobe is combinational and high in the cycle whose edge drives sck 1->0.
// Backpressure: none; run=0 synchronously parks the prescaler and sck at 0.
module i2s_sck_gen #(
  parameter int DIVIDER = 4
) (
  input  logic ck,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic fall
);

  localparam int             PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [PW-1:0]  TC = PW'(DIVIDER - 1);

  logic [PW-1:0] r_presc;
  logic          r_sck;
  logic          w_tc;

  assign w_tc = run && (r_presc == TC);
  assign fall = w_tc && r_sck;
  assign sck  = r_sck;

  // Prescaler and bit-clock toggle; both held at 0 while not running.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_sck   <= 1'b0;
    end else if (!run) begin
      r_presc <= '0;
      r_sck   <= 1'b0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_sck   <= ~r_sck;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S master frame controller: sck/ws generation, frame position, per-frame sample-pair capture.
// Latency: pair captured on the 50->51 slot edge; out_valid rises on that same edge.
// Backpressure: valid/ready; a capture while a pair is still unaccepted is dropped and flags sticky overrun.
module i2s_frame_ctrl
  import i2s_frame_ctrl_pkg::*;
#(
  parameter int DIVIDER = 4
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        en,
  output logic        sck,
  output logic        ws,
  output logic [5:0]  frame_posn,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_left,
  output logic [15:0] out_right,
  output logic [7:0]  out_seq,
  output logic        overrun,
  input  logic        clr_overrun,
  output logic        running
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_posn;
  logic        r_ws;
  logic [7:0]  r_frame_cnt;
  logic        r_out_valid;
  logic [15:0] r_out_left;
  logic [15:0] r_out_right;
  logic [7:0]  r_out_seq;
  logic        r_overrun;

  logic        w_run;
  logic        w_fall;
  logic        w_wrap;
  logic        w_capture;
  logic        w_xfer;
  logic        w_load;
  logic        w_drop;
  logic [5:0]  w_posn_nxt;

  assign w_run      = (r_state != IDLE);
  assign w_posn_nxt = posn_inc(r_posn);
  assign w_wrap     = w_fall && (r_posn == 6'(FRAME_LEN - 1));
  assign w_capture  = w_fall && (r_posn == 6'(CAPTURE_POSN));
  assign w_xfer     = r_out_valid && out_ready;
  // A capture may load only if the slot is free or is being emptied this cycle.
  assign w_load     = w_capture && (!r_out_valid || w_xfer);
  assign w_drop     = w_capture && r_out_valid && !out_ready;

  i2s_sck_gen #(
    .DIVIDER (DIVIDER)
  ) u_sck_gen (
    .ck    (ck),
    .rst_n (rst_n),
    .run   (w_run),
    .sck   (sck),
    .fall  (w_fall)
  );

  // Controller state register.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: stopping only ends on a frame boundary, so no partial frame is emitted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (en) w_state_nxt = RUN;
      RUN:      if (!en) w_state_nxt = STOPPING;
      STOPPING: begin
        if (en)          w_state_nxt = RUN;
        else if (w_wrap) w_state_nxt = IDLE;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Frame position and word select advance together on each sck falling edge.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_posn <= '0;
      r_ws   <= 1'b0;
    end else if (r_state == IDLE) begin
      r_posn <= '0;
      r_ws   <= 1'b0;
    end else if (w_fall) begin
      r_posn <= w_posn_nxt;
      r_ws   <= (w_posn_nxt >= 6'(WORD_LEN));
    end
  end

  // Frame counter advances on every capture, whether the pair is kept or dropped.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)         r_frame_cnt <= '0;
    else if (w_capture) r_frame_cnt <= r_frame_cnt + 8'd1;
  end

  // Output holding register with valid/ready handshake.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_left  <= '0;
      r_out_right <= '0;
      r_out_seq   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_left  <= left_in;
      r_out_right <= right_in;
      r_out_seq   <= r_frame_cnt;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)           r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
    else if (clr_overrun) r_overrun <= 1'b0;
  end

  assign ws         = r_ws;
  assign frame_posn = r_posn;
  assign out_valid  = r_out_valid;
  assign out_left   = r_out_left;
  assign out_right  = r_out_right;
  assign out_seq    = r_out_seq;
  assign overrun    = r_overrun;
  assign running    = w_run;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl with DIVIDER=2 (sck period 4 ck, frame 256 ck).
// k counts posedges after reset release with en=1; edge 0 enters RUN, sck toggles on even edges >= 2,
// frame_posn advances on edges 4,8,..., so the 50->51 capture lands on edge 204 + 256*n.
module tb_i2s_frame_ctrl;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sck;
  logic        ws;
  logic [5:0]  frame_posn;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic [7:0]  out_seq;
  logic        overrun;
  logic        clr_overrun;
  logic        running;

  int n_vec = 0;
  int n_err = 0;
  int k     = 0;

  i2s_frame_ctrl #(.DIVIDER(2)) dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .en          (en),
    .sck         (sck),
    .ws          (ws),
    .frame_posn  (frame_posn),
    .left_in     (left_in),
    .right_in    (right_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_left    (out_left),
    .out_right   (out_right),
    .out_seq     (out_seq),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .running     (running)
  );

  always #5 ck = ~ck;

  typedef struct {
    int         k;
    logic [5:0] posn;
    logic       ws;
    logic       sck;
    logic       valid;
    logic       chk_seq;
    logic [7:0] seq;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (k=%0d)", nm, act, exp, k);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " sck"},       64'(sck),        64'd0);
    chk({nm, " ws"},        64'(ws),         64'd0);
    chk({nm, " posn"},      64'(frame_posn), 64'd0);
    chk({nm, " valid"},     64'(out_valid),  64'd0);
    chk({nm, " data"},      {32'd0, out_left, out_right}, 64'd0);
    chk({nm, " seq"},       64'(out_seq),    64'd0);
    chk({nm, " overrun"},   64'(overrun),    64'd0);
    chk({nm, " running"},   64'(running),    64'd0);
  endtask

  // Advance to #1 after posedge number t.
  task automatic run_to(input int t);
    while (k < t) begin
      @(posedge ck);
      k++;
    end
    #1;
  endtask

  // Assert reset mid-cycle and check outputs clear without a clock edge.
  task automatic apply_reset(input string nm);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(nm);
  endtask

  // Release reset just after a posedge; the next posedge is edge 0.
  task automatic start(input logic en_v);
    @(posedge ck);
    #1;
    rst_n = 1'b1;
    en    = en_v;
    k     = -1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
    left_in = '0; right_in = '0;

    //          k    posn   ws    sck   valid chk   seq
    tbl[0]  = '{0,   6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1,   6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{2,   6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{4,   6'd1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{127, 6'd31, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{128, 6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{203, 6'd50, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{204, 6'd51, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[8]  = '{205, 6'd51, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{255, 6'd63, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{256, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[11] = '{460, 6'd51, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[12] = '{461, 6'd51, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[13] = '{716, 6'd51, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[14] = '{717, 6'd51, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    repeat (2) @(posedge ck);
    #1;
    chk_zero("por");

    // Free-running frames with a consumer that is always ready.
    left_in = 16'h1234; right_in = 16'hABCD; out_ready = 1'b1;
    start(1'b1);
    for (int i = 0; i < 15; i++) begin
      run_to(tbl[i].k);
      chk($sformatf("v%0d posn", i),  64'(frame_posn), 64'(tbl[i].posn));
      chk($sformatf("v%0d ws", i),    64'(ws),         64'(tbl[i].ws));
      chk($sformatf("v%0d sck", i),   64'(sck),        64'(tbl[i].sck));
      chk($sformatf("v%0d valid", i), 64'(out_valid),  64'(tbl[i].valid));
      if (tbl[i].chk_seq) begin
        chk($sformatf("v%0d seq", i),  64'(out_seq), 64'(tbl[i].seq));
        chk($sformatf("v%0d data", i), {32'd0, out_left, out_right}, 64'h1234ABCD);
      end
    end

    // Overrun: consumer stalls for three frames, then clears and accepts.
    apply_reset("rst_ovr");
    left_in = 16'h1111; right_in = 16'h2222; out_ready = 1'b0;
    start(1'b1);
    run_to(204);
    chk("ovr first valid", 64'(out_valid), 64'd1);
    left_in = 16'h5555; right_in = 16'h6666;
    run_to(459);
    chk("ovr pre", 64'(overrun), 64'd0);
    run_to(460);
    chk("ovr set f1", 64'(overrun), 64'd1);
    chk("ovr held data f1", {32'd0, out_left, out_right}, 64'h11112222);
    run_to(717);
    chk("ovr set f2", 64'(overrun), 64'd1);
    chk("ovr held seq", 64'(out_seq), 64'd0);
    chk("ovr held valid", 64'(out_valid), 64'd1);
    clr_overrun = 1'b1; out_ready = 1'b1;
    run_to(718);
    clr_overrun = 1'b0; out_ready = 1'b0;
    chk("ovr cleared", 64'(overrun), 64'd0);
    chk("ovr accepted", 64'(out_valid), 64'd0);
    run_to(972);
    chk("ovr next valid", 64'(out_valid), 64'd1);
    chk("ovr next seq", 64'(out_seq), 64'd3);
    chk("ovr next data", {32'd0, out_left, out_right}, 64'h55556666);

    // Capture coincident with a transfer: new pair replaces the old one.
    apply_reset("rst_coin");
    left_in = 16'h1111; right_in = 16'h2222; out_ready = 1'b0;
    start(1'b1);
    run_to(204);
    left_in = 16'h3333; right_in = 16'h4444;
    run_to(459);
    chk("coin pre valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    run_to(460);
    out_ready = 1'b0;
    chk("coin valid", 64'(out_valid), 64'd1);
    chk("coin seq", 64'(out_seq), 64'd1);
    chk("coin data", {32'd0, out_left, out_right}, 64'h33334444);
    chk("coin overrun", 64'(overrun), 64'd0);
    run_to(461);
    chk("coin held", 64'(out_valid), 64'd1);

    // Stop request, resume while stopping, then stop through to IDLE.
    apply_reset("rst_stop");
    out_ready = 1'b1;
    start(1'b1);
    run_to(40);
    chk("stop posn10", 64'(frame_posn), 64'd10);
    en = 1'b0;
    run_to(41);
    chk("stopping running", 64'(running), 64'd1);
    run_to(160);
    chk("stopping posn40", 64'(frame_posn), 64'd40);
    en = 1'b1;
    run_to(256);
    chk("resume wrap posn", 64'(frame_posn), 64'd0);
    chk("resume running", 64'(running), 64'd1);
    run_to(300);
    chk("resume posn11", 64'(frame_posn), 64'd11);
    en = 1'b0; out_ready = 1'b0;
    run_to(460);
    chk("stopping capture valid", 64'(out_valid), 64'd1);
    chk("stopping capture seq", 64'(out_seq), 64'd1);
    run_to(511);
    chk("last slot posn", 64'(frame_posn), 64'd63);
    chk("last slot sck", 64'(sck), 64'd1);
    chk("last slot running", 64'(running), 64'd1);
    run_to(512);
    chk("idle running", 64'(running), 64'd0);
    chk("idle posn", 64'(frame_posn), 64'd0);
    chk("idle sck", 64'(sck), 64'd0);
    run_to(600);
    chk("idle still", {58'd0, sck, running, frame_posn[3:0]}, 64'd0);
    chk("idle valid persists", 64'(out_valid), 64'd1);

    // Asynchronous reset mid-frame with a pair pending, then restart.
    apply_reset("rst_async_pre");
    left_in = 16'h1234; right_in = 16'hABCD; out_ready = 1'b0; en = 1'b1;
    start(1'b1);
    run_to(336);
    chk("async pre posn", 64'(frame_posn), 64'd20);
    chk("async pre valid", 64'(out_valid), 64'd1);
    apply_reset("async");
    start(1'b1);
    run_to(3);
    chk("restart posn0", 64'(frame_posn), 64'd0);
    run_to(4);
    chk("restart posn1", 64'(frame_posn), 64'd1);
    run_to(204);
    chk("restart valid", 64'(out_valid), 64'd1);
    chk("restart seq", 64'(out_seq), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
